mul_fu_scheduler: RTL and testbench

Sequences the shared multi-cycle multiplier functional unit and arbitrates it between NUM_REQ issuing stations (reservation stations / scoreboard issue slots). The block performs round-robin grant, latches operands and tag, pulses the FU enable and waits for the FU's finish. It then holds the tagged result on a writeback port until the common-data-bus arbiter acknowledges it. Only one multiply is in flight at a time.

---
 rtl/mul_fu_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_mul_fu_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_fu_scheduler.sv
// mul_fu_scheduler: round-robin arbiter and sequencer for a shared multi-cycle
// multiplier. It grants one requester, starts the FU, waits for its finish
// strobe and holds the tagged result on the writeback port until it is acked.
// Optional build macro MUL_TIMEOUT_EN adds a watchdog on the FU finish strobe
// that raises a sticky err and forces a zero-data writeback so the consumer
// never deadlocks.
module mul_fu_scheduler #(
   parameter int NUM_REQ = 2,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   input  logic [NUM_REQ*32-1:0]    i_req_a,
   input  logic [NUM_REQ*32-1:0]    i_req_b,
   input  logic [NUM_REQ*TAG_W-1:0] i_req_tag,
   output logic [NUM_REQ-1:0]       o_req_grant,
   output logic                     o_fu_en,
   output logic [31:0]              o_fu_a,
   output logic [31:0]              o_fu_b,
   input  logic [31:0]              i_fu_res,
   input  logic                     i_fu_finish,
   output logic                     o_wb_valid,
   output logic [31:0]              o_wb_data,
   output logic [TAG_W-1:0]         o_wb_tag,
   input  logic                     i_wb_ack,
   output logic                     o_busy,
   output logic                     o_err
);

   localparam int PTR_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WB    = 2'd3
   } state_t;

   state_t             r_state;
   logic [PTR_W-1:0]   r_rr_ptr;
   logic [TAG_W-1:0]   r_tag;
   logic               r_fu_en;
   logic [31:0]        r_fu_a;
   logic [31:0]        r_fu_b;
   logic               r_wb_valid;
   logic [31:0]        r_wb_data;
   logic [TAG_W-1:0]   r_wb_tag;
   logic               r_busy;

   logic               w_found;
   logic [PTR_W-1:0]   w_idx;
   logic [PTR_W:0]     w_cand;
   logic [PTR_W-1:0]   w_next_ptr;
   logic [31:0]        w_sel_a;
   logic [31:0]        w_sel_b;
   logic [TAG_W-1:0]   w_sel_tag;

   // Round-robin search: first valid requester at or above r_rr_ptr, wrapping.
   // NOTE: every variable assigned in a combinational block gets a default
   // first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
         if (w_cand >= (PTR_W+1)'(NUM_REQ))
            w_cand = w_cand - (PTR_W+1)'(NUM_REQ);
         if (!w_found && i_req_valid[w_cand[PTR_W-1:0]]) begin
            w_found = 1'b1;
            w_idx   = w_cand[PTR_W-1:0];
         end
      end
   end

   // Operand/tag mux for the winning requester and the rotated pointer.
   always_comb begin
      w_sel_a    = i_req_a[w_idx*32 +: 32];
      w_sel_b    = i_req_b[w_idx*32 +: 32];
      w_sel_tag  = i_req_tag[w_idx*TAG_W +: TAG_W];
      w_next_ptr = (w_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;
   end

   // Grants are only issued while idle; one-hot on the selected requester.
   always_comb begin
      o_req_grant = '0;
      if (r_state == ST_IDLE && w_found)
         o_req_grant = NUM_REQ'(1) << w_idx;
   end

`ifdef MUL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
`endif

   // Operation sequencer: IDLE -> START -> WAIT -> WB -> IDLE, all outputs registered.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_rr_ptr   <= '0;
         r_tag      <= '0;
         r_fu_en    <= 1'b0;
         r_fu_a     <= '0;
         r_fu_b     <= '0;
         r_wb_valid <= 1'b0;
         r_wb_data  <= '0;
         r_wb_tag   <= '0;
         r_busy     <= 1'b0;
`ifdef MUL_TIMEOUT_EN
         r_cnt      <= '0;
         r_err      <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_fu_a   <= w_sel_a;
                  r_fu_b   <= w_sel_b;
                  r_tag    <= w_sel_tag;
                  r_rr_ptr <= w_next_ptr;
                  r_fu_en  <= 1'b1;
                  r_busy   <= 1'b1;
                  r_state  <= ST_START;
               end
            end
            ST_START: begin
               r_fu_en <= 1'b0;
`ifdef MUL_TIMEOUT_EN
               r_cnt   <= '0;
`endif
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
`ifdef MUL_TIMEOUT_EN
               r_cnt <= r_cnt + 1'b1;
`endif
               if (i_fu_finish) begin
                  r_wb_data  <= i_fu_res;
                  r_wb_tag   <= r_tag;
                  r_wb_valid <= 1'b1;
                  r_state    <= ST_WB;
               end
`ifdef MUL_TIMEOUT_EN
               else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  // Missing finish: flag it and release the consumer with zero data.
                  r_err      <= 1'b1;
                  r_wb_data  <= '0;
                  r_wb_tag   <= r_tag;
                  r_wb_valid <= 1'b1;
                  r_state    <= ST_WB;
               end
`endif
            end
            ST_WB: begin
               if (i_wb_ack) begin
                  r_wb_valid <= 1'b0;
                  r_busy     <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_fu_en    = r_fu_en;
   assign o_fu_a     = r_fu_a;
   assign o_fu_b     = r_fu_b;
   assign o_wb_valid = r_wb_valid;
   assign o_wb_data  = r_wb_data;
   assign o_wb_tag   = r_wb_tag;
   assign o_busy     = r_busy;
`ifdef MUL_TIMEOUT_EN
   assign o_err      = r_err;
`else
   assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mul_fu_scheduler.sv
// Directed bench for mul_fu_scheduler: single op, round-robin rotation,
// writeback backpressure, reset mid-operation, wrap/truncation and spurious
// finish strobes, plus the timeout path when MUL_TIMEOUT_EN is defined.
module tb_mul_fu_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [7:0]  req_tag;
   logic [1:0]  req_grant;
   logic        fu_en;
   logic [31:0] fu_a;
   logic [31:0] fu_b;
   logic [31:0] fu_res;
   logic        fu_finish;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [3:0]  wb_tag;
   logic        wb_ack;
   logic        busy;
   logic        err;

   int n_cmp  = 0;
   int n_fail = 0;

   mul_fu_scheduler #(.NUM_REQ(2), .TAG_W(4), .TIMEOUT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_req_valid (req_valid),
      .i_req_a     (req_a),
      .i_req_b     (req_b),
      .i_req_tag   (req_tag),
      .o_req_grant (req_grant),
      .o_fu_en     (fu_en),
      .o_fu_a      (fu_a),
      .o_fu_b      (fu_b),
      .i_fu_res    (fu_res),
      .i_fu_finish (fu_finish),
      .o_wb_valid  (wb_valid),
      .o_wb_data   (wb_data),
      .o_wb_tag    (wb_tag),
      .i_wb_ack    (wb_ack),
      .o_busy      (busy),
      .o_err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_tag = '0;
      fu_res = '0; fu_finish = 1'b0; wb_ack = 1'b0;
      #2;
      check("rst_fu_en",    32'(fu_en),     32'd0);
      check("rst_fu_a",     fu_a,           32'd0);
      check("rst_fu_b",     fu_b,           32'd0);
      check("rst_wb_valid", 32'(wb_valid),  32'd0);
      check("rst_wb_data",  wb_data,        32'd0);
      check("rst_wb_tag",   32'(wb_tag),    32'd0);
      check("rst_busy",     32'(busy),      32'd0);
      check("rst_err",      32'(err),       32'd0);
      check("rst_grant",    32'(req_grant), 32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // ---- single operation ----
      req_valid = 2'b01; req_a[31:0] = 32'd3; req_b[31:0] = 32'd5; req_tag[3:0] = 4'd2;
      #1;
      check("s_grant",      32'(req_grant), 32'd1);
      check("s_busy_idle",  32'(busy),      32'd0);
      tick();                                     // START
      check("s_fu_en",      32'(fu_en),     32'd1);
      check("s_fu_a",       fu_a,           32'd3);
      check("s_fu_b",       fu_b,           32'd5);
      check("s_busy",       32'(busy),      32'd1);
      check("s_grant_start",32'(req_grant), 32'd0);
      req_valid = 2'b00;
      tick();                                     // WAIT, one cycle after fu_en
      check("s_fu_en_pulse",32'(fu_en),     32'd0);
      repeat (6) begin
         check("s_wb_wait",  32'(wb_valid),  32'd0);
         tick();
      end
      fu_finish = 1'b1; fu_res = 32'd15;          // 7 cycles after fu_en
      tick();                                     // WB
      fu_finish = 1'b0;
      repeat (3) begin
         check("s_wb_valid", 32'(wb_valid),  32'd1);
         check("s_wb_data",  wb_data,        32'd15);
         check("s_wb_tag",   32'(wb_tag),    32'd2);
         tick();
      end
      wb_ack = 1'b1;
      tick();                                     // IDLE
      wb_ack = 1'b0;
      check("s_wb_clear",   32'(wb_valid),  32'd0);
      check("s_busy_clear", 32'(busy),      32'd0);
      check("s_fu_a_kept",  fu_a,           32'd3);

      // Reset so the round-robin pointer restarts at requester 0.
      rst = 1'b1; tick(); rst = 1'b0; tick();

      // ---- round robin, both requesters valid, ack tied high ----
      req_valid = 2'b11;
      req_a = {32'd22, 32'd11}; req_b = {32'd44, 32'd33}; req_tag = {4'h5, 4'hA};
      wb_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("rr_grant",   32'(req_grant), (i % 2 == 0) ? 32'd1 : 32'd2);
         tick();                                  // START
         check("rr_fu_a",    fu_a,           (i % 2 == 0) ? 32'd11 : 32'd22);
         check("rr_fu_b",    fu_b,           (i % 2 == 0) ? 32'd33 : 32'd44);
         tick();                                  // WAIT
         fu_finish = 1'b1; fu_res = 32'(100 + i);
         tick();                                  // WB
         fu_finish = 1'b0;
         check("rr_wb_data", wb_data,        32'(100 + i));
         check("rr_wb_tag",  32'(wb_tag),    (i % 2 == 0) ? 32'hA : 32'h5);
         tick();                                  // IDLE
      end
      wb_ack = 1'b0;

      // ---- writeback backpressure, req_valid=11 ----
      #1;
      check("bp_grant",     32'(req_grant), 32'd1);
      tick(); tick();                             // START, WAIT
      fu_finish = 1'b1; fu_res = 32'h1234_5678;
      tick();                                     // WB
      fu_finish = 1'b0;
      repeat (10) begin
         check("bp_wb_valid", 32'(wb_valid),  32'd1);
         check("bp_wb_data",  wb_data,        32'h1234_5678);
         check("bp_wb_tag",   32'(wb_tag),    32'hA);
         check("bp_busy",     32'(busy),      32'd1);
         check("bp_no_grant", 32'(req_grant), 32'd0);
         tick();
      end
      wb_ack = 1'b1;
      tick();                                     // IDLE
      wb_ack = 1'b0;
      check("bp_wb_clear",  32'(wb_valid),  32'd0);
      check("bp_next_grant",32'(req_grant), 32'd2);
      req_valid = 2'b00;

      // ---- reset mid-WAIT; pointer is 1 so requester 0 is found by wrap ----
      req_valid = 2'b01; req_a[31:0] = 32'd7; req_b[31:0] = 32'd9; req_tag[3:0] = 4'd3;
      #1;
      check("rw_grant_wrap",32'(req_grant), 32'd1);
      tick();                                     // START
      req_valid = 2'b00;
      tick(); tick(); tick();                     // WAIT, 3 cycles after fu_en
      rst = 1'b1;
      #1;
      check("rw_wb_valid",  32'(wb_valid),  32'd0);
      check("rw_busy",      32'(busy),      32'd0);
      check("rw_fu_en",     32'(fu_en),     32'd0);
      check("rw_fu_a",      fu_a,           32'd0);
      check("rw_fu_b",      fu_b,           32'd0);
      tick();
      rst = 1'b0;
      tick();
      fu_finish = 1'b1; fu_res = 32'h55;          // late finish from the FU
      tick();
      fu_finish = 1'b0;
      check("rw_late_fin",  32'(wb_valid),  32'd0);
      check("rw_late_busy", 32'(busy),      32'd0);

      // ---- wrap/truncation and spurious finish strobes ----
      fu_finish = 1'b1; fu_res = 32'hDEAD;        // in IDLE
      tick();
      fu_finish = 1'b0;
      check("tr_idle_fin",  32'(wb_valid),  32'd0);
      req_valid = 2'b10; req_a[63:32] = 32'hFFFF_FFFF; req_b[63:32] = 32'd2; req_tag[7:4] = 4'd7;
      #1;
      check("tr_grant",     32'(req_grant), 32'd2);
      tick();                                     // START
      req_valid = 2'b00;
      fu_finish = 1'b1; fu_res = 32'h1111;        // in START
      check("tr_fu_a",      fu_a,           32'hFFFF_FFFF);
      check("tr_fu_b",      fu_b,           32'd2);
      tick();                                     // WAIT
      fu_finish = 1'b0;
      check("tr_start_fin", 32'(wb_valid),  32'd0);
      tick();
      fu_finish = 1'b1; fu_res = 32'hFFFF_FFFE;
      tick();                                     // WB
      fu_res = 32'h0BAD;                          // finish still high in WB
      check("tr_wb_data",   wb_data,        32'hFFFF_FFFE);
      check("tr_wb_tag",    32'(wb_tag),    32'd7);
      tick();
      fu_finish = 1'b0;
      check("tr_wb_hold",   wb_data,        32'hFFFF_FFFE);
      wb_ack = 1'b1;
      tick();                                     // IDLE
      check("tr_wb_clear",  32'(wb_valid),  32'd0);
      check("tr_fu_a_kept", fu_a,           32'hFFFF_FFFF);
      tick();                                     // ack with nothing pending
      wb_ack = 1'b0;
      check("ack_idle_busy",32'(busy),      32'd0);
      check("ack_idle_wbv", 32'(wb_valid),  32'd0);

`ifdef MUL_TIMEOUT_EN
      // ---- FU never finishes ----
      req_valid = 2'b01; req_tag[3:0] = 4'hC;
      tick();                                     // START
      req_valid = 2'b00;
      tick();                                     // enter WAIT
      repeat (15) begin
         check("to_wb_wait", 32'(wb_valid),  32'd0);
         check("to_err_wait",32'(err),       32'd0);
         tick();
      end
      tick();                                     // 16 cycles after entering WAIT
      check("to_wb_valid",  32'(wb_valid),  32'd1);
      check("to_err",       32'(err),       32'd1);
      check("to_wb_data",   wb_data,        32'd0);
      check("to_wb_tag",    32'(wb_tag),    32'hC);
      wb_ack = 1'b1;
      tick();
      wb_ack = 1'b0;
      check("to_wb_clear",  32'(wb_valid),  32'd0);
      check("to_err_sticky",32'(err),       32'd1);
`else
      check("err_tied",     32'(err),       32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
